s3g_tx_pkt: RTL

//  Parametrised S3G packet transmitter: frames payload bytes as D5,LEN,payload,CRC8 onto a byte UART.

---
 rtl/s3g_pkg.sv | 25 ++
 rtl/s3g_tx_pkt_if.sv | 26 ++
 rtl/s3g_tx_buf.sv | 25 ++
 rtl/s3g_tx_pkt.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/s3g_pkg.sv
// Shared definitions for the S3G packet transmitter: start byte, frame FSM
// states and the byte-wise CRC-8 update (poly 0x07, MSB first, init 0).
package s3g_pkg;

  localparam logic [7:0] S3G_START_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LEN,
    S_DATA,
    S_CRC
  } state_e;

  // Folds one data byte into the running CRC, most significant bit first.
  function automatic logic [7:0] crc8_d8(input logic [7:0] data, input logic [7:0] crc);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_tx_pkt_if.sv
// Host-side payload/command signals and UART-side byte handshake of the
// S3G packet transmitter, bundled with host (master) and DUT (slave) views.
interface s3g_tx_pkt_if #(
  parameter int LEN_W = 6
);
  logic [7:0]       pl_data;
  logic             pl_wr;
  logic             packet_wr;
  logic             retx;
  logic             busy;
  logic [LEN_W-1:0] pl_count;
  logic             err;
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             tx_done;

  modport master (
    output pl_data, pl_wr, packet_wr, retx, tx_done,
    input  busy, pl_count, err, tx_data, tx_wr
  );

  modport slave (
    input  pl_data, pl_wr, packet_wr, retx, tx_done,
    output busy, pl_count, err, tx_data, tx_wr
  );
endinterface

// File: rtl/s3g_tx_buf.sv
// Payload byte store for the S3G transmitter: synchronous write, asynchronous
// read so the FSM can present buf[idx] in the same cycle tx_done arrives.
module s3g_tx_buf #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: storage has no reset; every location is written before the FSM can
  // read it, and a reset would turn the array into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/s3g_tx_pkt.sv
// S3G packet transmitter: frames buffered payload as START,LEN,payload,CRC8
// onto a byte UART. Define S3G_TX_RETX_EN to enable last-packet resend (retx).
module s3g_tx_pkt
  import s3g_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 32,
  parameter logic [7:0] START_BYTE  = S3G_START_BYTE,
  localparam int        LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  s3g_tx_pkt_if.slave  bus
);

`ifdef S3G_TX_RETX_EN
  localparam bit RETX_EN = 1'b1;
`else
  localparam bit RETX_EN = 1'b0;
`endif

  localparam int               ADDR_W  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_PAYLOAD);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_wr_q, tx_wr_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             last_ok_q, last_ok_d;
  logic             buf_we;
  logic             start;
  logic [7:0]       buf_rdata;

  s3g_tx_buf #(
    .DEPTH  (MAX_PAYLOAD),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (bus.pl_data),
    .raddr (idx_q[ADDR_W-1:0]),
    .rdata (buf_rdata)
  );

  // NOTE: every variable gets its hold/idle value first so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    busy_d    = busy_q;
    err_d     = 1'b0;
    last_ok_d = last_ok_q;
    buf_we    = 1'b0;
    start     = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.pl_wr) begin
        if (cnt_q != MAX_CNT) begin
          buf_we    = 1'b1;
          cnt_d     = cnt_q + ONE;
          last_ok_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      // cnt_d already includes a byte appended in this same cycle.
      if (bus.packet_wr) begin
        start = 1'b1;
        len_d = cnt_d;
      end else if (RETX_EN && bus.retx) begin
        // len_q still holds the previous frame length; a concurrent pl_wr
        // is starting a new payload, so the old packet is no longer valid.
        if (last_ok_q && !bus.pl_wr) start = 1'b1;
        else                         err_d = 1'b1;
      end
      if (start) begin
        state_d   = S_START;
        tx_data_d = START_BYTE;
        tx_wr_d   = 1'b1;
        busy_d    = 1'b1;
        idx_d     = '0;
        crc_d     = '0;
      end
    end else begin
      if (bus.pl_wr || bus.packet_wr || (RETX_EN && bus.retx)) err_d = 1'b1;
      if (bus.tx_done) begin
        tx_wr_d = 1'b1;
        case (state_q)
          S_START: begin
            tx_data_d = 8'(len_q);
            state_d   = S_LEN;
          end
          S_LEN, S_DATA: begin
            if (idx_q != len_q) begin
              tx_data_d = buf_rdata;
              crc_d     = crc8_d8(buf_rdata, crc_q);
              idx_d     = idx_q + ONE;
              state_d   = S_DATA;
            end else begin
              tx_data_d = crc_q;
              state_d   = S_CRC;
            end
          end
          S_CRC: begin
            tx_wr_d   = 1'b0;
            busy_d    = 1'b0;
            cnt_d     = '0;
            last_ok_d = RETX_EN;
            state_d   = S_IDLE;
          end
          default: begin
            tx_wr_d = 1'b0;
            state_d = S_IDLE;
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed above for this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      last_ok_q <= last_ok_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.pl_count = cnt_q;
  assign bus.err      = err_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_wr    = tx_wr_q;

endmodule
